// File: rtl/boot_copy_seq.sv
// boot_copy_seq: Wishbone master that copies the boot image from ROM to RAM
// while holding the CPU off the bus, then writes the boot control register
// (RAM enable plus a CPU reset pulse) and releases the CPU.
// Every bus transfer is separated from the next by one cycle with cyc/stb low.
module boot_copy_seq #(
  parameter logic [31:0] SRC_BASE  = 32'h0000_0000,
  parameter logic [31:0] DST_BASE  = 32'h0010_0000,
  parameter logic [31:0] LEN_WORDS = 32'd1024,
  parameter logic [31:0] CTRL_ADDR = 32'h00F0_0000,
  parameter logic [31:0] TIMEOUT   = 32'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        start_i,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o
);

  // Control byte lives in lane 3: bit25 RAM_ENABLE, bit24 CPU reset, bit26 BOOT_SEL=0
  localparam logic [31:0] CTRL_WORD = 32'h0300_0000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_CTRL = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] index_r, index_s;
  logic [31:0] tcnt_r, tcnt_s;
  logic [31:0] rdata_r, rdata_s;
  logic [31:0] adr_r, adr_s;
  logic [31:0] dat_r, dat_s;
  logic [3:0]  sel_r, sel_s;
  logic        we_r, we_s;
  logic        cyc_r, cyc_s;
  logic        stb_r, stb_s;
  logic        hold_r, hold_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        error_r, error_s;
  logic        fault_s;
  logic [31:0] index_inc_s;

  // State and all output registers; reset abandons any bus cycle at once
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_r <= ST_IDLE;
      index_r <= 32'd0;
      tcnt_r  <= 32'd0;
      rdata_r <= 32'd0;
      adr_r   <= 32'd0;
      dat_r   <= 32'd0;
      sel_r   <= 4'd0;
      we_r    <= 1'b0;
      cyc_r   <= 1'b0;
      stb_r   <= 1'b0;
      hold_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      index_r <= index_s;
      tcnt_r  <= tcnt_s;
      rdata_r <= rdata_s;
      adr_r   <= adr_s;
      dat_r   <= dat_s;
      sel_r   <= sel_s;
      we_r    <= we_s;
      cyc_r   <= cyc_s;
      stb_r   <= stb_s;
      hold_r  <= hold_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      error_r <= error_s;
    end
  end

  // Next state and next outputs; bus outputs default low (gap / idle) and are
  // explicitly held or raised by the branch that keeps a transfer alive
  always_comb begin
    state_s     = state_r;
    index_s     = index_r;
    tcnt_s      = tcnt_r;
    rdata_s     = rdata_r;
    adr_s       = 32'd0;
    dat_s       = 32'd0;
    sel_s       = 4'd0;
    we_s        = 1'b0;
    cyc_s       = 1'b0;
    stb_s       = 1'b0;
    hold_s      = hold_r;
    busy_s      = busy_r;
    done_s      = done_r;
    error_s     = error_r;
    index_inc_s = index_r + 32'd1;
    // err wins over ack; a timeout only fires when no ack arrives
    fault_s     = stb_r && (wbm_err_i || (!wbm_ack_i && (tcnt_r == TIMEOUT - 32'd1)));

    if (fault_s) begin
      state_s = ST_ERR;
      error_s = 1'b1;
      busy_s  = 1'b0;
    end else if (stb_r && !wbm_ack_i) begin
      // waiting for the slave: keep the request stable
      adr_s  = adr_r;
      dat_s  = dat_r;
      sel_s  = sel_r;
      we_s   = we_r;
      cyc_s  = 1'b1;
      stb_s  = 1'b1;
      tcnt_s = tcnt_r + 32'd1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            index_s = 32'd0;
            tcnt_s  = 32'd0;
            hold_s  = 1'b1;
            busy_s  = 1'b1;
            cyc_s   = 1'b1;
            stb_s   = 1'b1;
            if (LEN_WORDS == 32'd0) begin
              state_s = ST_CTRL;
              adr_s   = CTRL_ADDR;
              dat_s   = CTRL_WORD;
              sel_s   = 4'b1000;
              we_s    = 1'b1;
            end else begin
              state_s = ST_RD;
              adr_s   = SRC_BASE;
              sel_s   = 4'hF;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RD: begin
          if (stb_r) begin
            rdata_s = wbm_dat_i;
            state_s = ST_WR;
          end else begin
            adr_s  = SRC_BASE + (index_r << 2);
            sel_s  = 4'hF;
            cyc_s  = 1'b1;
            stb_s  = 1'b1;
            tcnt_s = 32'd0;
          end
        end
        ST_WR: begin
          if (stb_r) begin
            index_s = index_inc_s;
            if (index_inc_s == LEN_WORDS) begin
              state_s = ST_CTRL;
            end else begin
              state_s = ST_RD;
            end
          end else begin
            adr_s  = DST_BASE + (index_r << 2);
            dat_s  = rdata_r;
            sel_s  = 4'hF;
            we_s   = 1'b1;
            cyc_s  = 1'b1;
            stb_s  = 1'b1;
            tcnt_s = 32'd0;
          end
        end
        ST_CTRL: begin
          if (stb_r) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            hold_s  = 1'b0;
            busy_s  = 1'b0;
          end else begin
            adr_s  = CTRL_ADDR;
            dat_s  = CTRL_WORD;
            sel_s  = 4'b1000;
            we_s   = 1'b1;
            cyc_s  = 1'b1;
            stb_s  = 1'b1;
            tcnt_s = 32'd0;
          end
        end
        ST_DONE: state_s = ST_DONE;
        ST_ERR:  state_s = ST_ERR;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  assign wbm_adr_o  = adr_r;
  assign wbm_dat_o  = dat_r;
  assign wbm_sel_o  = sel_r;
  assign wbm_we_o   = we_r;
  assign wbm_cyc_o  = cyc_r;
  assign wbm_stb_o  = stb_r;
  assign cpu_hold_o = hold_r;
  assign busy_o     = busy_r;
  assign done_o     = done_r;
  assign error_o    = error_r;

endmodule
